// File: rtl/gcd_req_driver_if.sv
// Bundles the operand, result and GCD-core signals of the requester.
// The master modport is the surroundings and the slave modport is the driver.
// Valid/ready rule: a transfer happens on any rising clk edge where valid && ready are both high.
// Once valid is raised, it stays high with stable payload until that transfer occurs.
interface gcd_req_driver_if #(
    parameter int NBits = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [NBits-1:0] in_a;
    logic [NBits-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [NBits-1:0] out_gcd;
    logic             out_err;
    logic             out_local;
    logic             start;
    logic [NBits-1:0] xi;
    logic [NBits-1:0] yi;
    logic [NBits-1:0] xo;
    logic             rdy;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, out_ready, xo, rdy,
        input  in_ready, out_valid, out_gcd, out_err, out_local, start, xi, yi, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready, xo, rdy,
        output in_ready, out_valid, out_gcd, out_err, out_local, start, xi, yi, busy
    );
endinterface

// File: rtl/gcd_req_driver.sv
// Requester for a start/rdy GCD core. It launches the core, captures xo when rdy rises,
// resolves trivial pairs locally and aborts a stalled core after TIMEOUT cycles.
module gcd_req_driver #(
    parameter int NBits   = 16,
    parameter int TIMEOUT = 1024,
    parameter bit BYPASS  = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    gcd_req_driver_if.slave     bus,
    output logic [2:0]          dbg_state_o
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        OUT       = 3'd4
    } state_e;

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 2);

    state_e           state_q;
    logic [NBits-1:0] xi_q;
    logic [NBits-1:0] yi_q;
    logic [NBits-1:0] out_gcd_q;
    logic             out_err_q;
    logic             out_local_q;
    logic [TW-1:0]    timer_q;
    logic             rdy_q;

    logic             any_zero;
    logic             trivial;
    logic [NBits-1:0] trivial_val;
    logic             rdy_rise;

    assign any_zero    = (bus.in_a == '0) || (bus.in_b == '0);
    assign trivial     = BYPASS && (any_zero || (bus.in_a == bus.in_b));
    assign trivial_val = any_zero ? (bus.in_a + bus.in_b) : bus.in_a;
    assign rdy_rise    = bus.rdy && !rdy_q;

    // The timer is compared one step early, so the abort lands TIMEOUT cycles after the start cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            xi_q        <= '0;
            yi_q        <= '0;
            out_gcd_q   <= '0;
            out_err_q   <= 1'b0;
            out_local_q <= 1'b0;
            timer_q     <= '0;
            rdy_q       <= 1'b0;
        end else begin
            rdy_q <= bus.rdy;
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (trivial) begin
                            out_gcd_q   <= trivial_val;
                            out_local_q <= 1'b1;
                            out_err_q   <= 1'b0;
                            state_q     <= OUT;
                        end else begin
                            xi_q    <= bus.in_a;
                            yi_q    <= bus.in_b;
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    timer_q <= '0;
                    state_q <= WAIT_BUSY;
                end
                WAIT_BUSY, WAIT_DONE: begin
                    timer_q <= timer_q + TW'(1);
                    if (rdy_rise) begin
                        out_gcd_q   <= bus.xo;
                        out_local_q <= 1'b0;
                        out_err_q   <= 1'b0;
                        state_q     <= OUT;
                    end else if (timer_q == TLAST) begin
                        out_gcd_q   <= '0;
                        out_local_q <= 1'b0;
                        out_err_q   <= 1'b1;
                        state_q     <= OUT;
                    end else if (state_q == WAIT_BUSY && !bus.rdy) begin
                        state_q <= WAIT_DONE;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.start     = (state_q == ISSUE);
    assign bus.out_valid = (state_q == OUT);
    assign bus.out_gcd   = out_gcd_q;
    assign bus.out_err   = out_err_q;
    assign bus.out_local = out_local_q;
    assign bus.xi        = xi_q;
    assign bus.yi        = yi_q;
    assign dbg_state_o   = state_q;
endmodule
